// File: rtl/seq_player.sv
// rtl/seq_player.sv - plays the stored game sequence one symbol at a time with on/gap timing
module seq_player #(
  parameter int DATA_W     = 4,
  parameter int ADDR_W     = 4,
  parameter int ON_CYCLES  = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMER_W    = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] last_idx,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] symbol,
  output logic              symbol_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [TIMER_W-1:0] ON_LAST  = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST = TIMER_W'(GAP_CYCLES - 1);

  state_t              state;
  logic [TIMER_W-1:0]  timer;
  logic [ADDR_W-1:0]   idx;
  logic [ADDR_W-1:0]   last_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      timer        <= '0;
      idx          <= '0;
      last_q       <= '0;
      rd_addr      <= '0;
      symbol       <= '0;
      symbol_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done    <= 1'b0;
          rd_addr <= '0;
          // rd_addr is already 0 here, so rd_data is entry 0 of the sequence
          if (start) begin
            last_q       <= last_idx;
            idx          <= '0;
            symbol       <= rd_data;
            symbol_valid <= 1'b1;
            busy         <= 1'b1;
            timer        <= '0;
            state        <= SHOW;
          end
        end

        SHOW: begin
          if (abort) begin
            state        <= IDLE;
            timer        <= '0;
            idx          <= '0;
            rd_addr      <= '0;
            symbol       <= '0;
            symbol_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
          end else if (timer == ON_LAST) begin
            timer        <= '0;
            symbol_valid <= 1'b0;
            if (idx == last_q) begin
              state   <= IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
              rd_addr <= '0;
            end else begin
              // Point the register file at the next entry during the gap
              state   <= GAP;
              rd_addr <= idx + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        GAP: begin
          if (abort) begin
            state        <= IDLE;
            timer        <= '0;
            idx          <= '0;
            rd_addr      <= '0;
            symbol       <= '0;
            symbol_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
          end else if (timer == GAP_LAST) begin
            timer        <= '0;
            idx          <= idx + 1'b1;
            symbol       <= rd_data;
            symbol_valid <= 1'b1;
            state        <= SHOW;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: begin
          state        <= IDLE;
          timer        <= '0;
          idx          <= '0;
          rd_addr      <= '0;
          symbol       <= '0;
          symbol_valid <= 1'b0;
          busy         <= 1'b0;
          done         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_player.sv
// tb/tb_seq_player.sv - self-checking bench for seq_player against a trace-level reference model
module tb_seq_player;

  localparam int ON  = 4;
  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [3:0] last_idx;
  logic [3:0] rd_data;
  logic [3:0] rd_addr;
  logic [3:0] symbol;
  logic       symbol_valid;
  logic       busy;
  logic       done;

  logic [3:0] regs [16];

  always #5 clk = ~clk;

  assign rd_data = regs[rd_addr];

  seq_player #(
    .DATA_W(4), .ADDR_W(4), .ON_CYCLES(ON), .GAP_CYCLES(GAP), .TIMER_W(24)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .last_idx(last_idx),
    .rd_data(rd_data), .rd_addr(rd_addr), .symbol(symbol),
    .symbol_valid(symbol_valid), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic       v;
    logic       b;
    logic       d;
    logic [3:0] s;
    logic [3:0] a;
  } exp_t;

  exp_t tr [$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected per-cycle outputs from the first cycle after start through the done cycle
  task automatic build_trace(input int last);
    tr.delete();
    for (int k = 0; k <= last; k++) begin
      for (int i = 0; i < ON; i++)
        tr.push_back('{v: 1'b1, b: 1'b1, d: 1'b0, s: regs[k], a: 4'(k)});
      if (k < last)
        for (int i = 0; i < GAP; i++)
          tr.push_back('{v: 1'b0, b: 1'b1, d: 1'b0, s: regs[k], a: 4'(k + 1)});
    end
    tr.push_back('{v: 1'b0, b: 1'b0, d: 1'b1, s: regs[last], a: 4'd0});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".rd_addr"}, rd_addr, 0);
    check({tag, ".symbol"}, symbol, 0);
    check({tag, ".valid"}, symbol_valid, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle.valid", symbol_valid, 0);
      check("idle.busy", busy, 0);
      check("idle.done", done, 0);
      check("idle.rd_addr", rd_addr, 0);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the done cycle (or after abort)
  task automatic run_seq(input int last, input int glitch_c, input int abort_c,
                         input int wr_c, input int wr_i, input logic [3:0] wr_v,
                         input bit abort_with_start);
    int busy_cnt;
    exp_t e;
    build_trace(last);
    start    = 1'b1;
    last_idx = 4'(last);
    abort    = abort_with_start;
    @(negedge clk);
    start    = 1'b0;
    abort    = 1'b0;
    last_idx = 4'($urandom);
    busy_cnt = 0;
    for (int c = 0; c < tr.size(); c++) begin
      e = tr[c];
      check("valid", symbol_valid, e.v);
      check("busy", busy, e.b);
      check("done", done, e.d);
      check("symbol", symbol, e.s);
      check("rd_addr", rd_addr, e.a);
      if (busy) busy_cnt++;
      if (c == abort_c) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_reset_vals("abort");
        return;
      end
      if (c == glitch_c) begin
        start    = 1'b1;
        last_idx = 4'($urandom);
      end
      if (c == wr_c) regs[wr_i] = wr_v;
      if (c < tr.size() - 1) begin
        @(negedge clk);
        start = 1'b0;
      end
    end
    check("busy_len", busy_cnt, (last + 1) * ON + last * GAP);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 4'($urandom);
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; last_idx = '0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    idle_cycles(1);

    regs[0] = 4'h5; regs[1] = 4'hA; regs[2] = 4'h3;
    run_seq(2, -1, -1, -1, 0, 4'h0, 1'b0);
    idle_cycles(1);

    regs[0] = 4'h9;
    run_seq(0, -1, -1, -1, 0, 4'h0, 1'b0);
    idle_cycles(1);

    for (int i = 0; i < 16; i++) regs[i] = 4'(i);
    run_seq(15, -1, -1, -1, 0, 4'h0, 1'b0);
    // start in the done cycle, together with abort: start must win
    run_seq(1, -1, -1, -1, 0, 4'h0, 1'b1);
    idle_cycles(2);

    for (int i = 0; i < 16; i++) regs[i] = 4'($urandom);
    run_seq(3, ON, ON + GAP + 1, -1, 0, 4'h0, 1'b0);
    idle_cycles(1);
    run_seq(3, -1, -1, -1, 0, 4'h0, 1'b0);
    idle_cycles(1);

    regs[1] = 4'h2;
    run_seq(2, -1, -1, ON + GAP + 1, 1, 4'hC, 1'b0);
    idle_cycles(1);
    run_seq(2, -1, -1, -1, 0, 4'h0, 1'b0);
    idle_cycles(1);

    start = 1'b1; last_idx = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("rst_mid");
    @(negedge clk);
    check_reset_vals("rst_hold");
    rst_n = 1'b1;
    idle_cycles(1);
    run_seq(1, -1, -1, -1, 0, 4'h0, 1'b0);

    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 16; i++) regs[i] = 4'($urandom);
      idle_cycles($urandom_range(0, 2));
      run_seq($urandom_range(0, 6), -1, -1, -1, 0, 4'h0, 1'b0);
    end
    idle_cycles(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
